nx_fifo_wr_arb: RTL and testbench
=================================

Name: nx_fifo_wr_arb

Overview:
- Round-robin write arbiter that shares one nx_fifo write port between N_REQ requesters.
- Packet-aware: once a requester wins, the grant is held until that requester's eop beat is written, so packets never interleave in the FIFO.
- Sits directly in front of the FIFO: drives its wen/wdata, observes its full flag, and tags each entry with the source id.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 611, data width per requester
- SRC_W, $clog2(N_REQ), width of the source id tag

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- clear  in  1  synchronous soft reset of arbitration state
- req_valid  in  N_REQ  per-requester beat valid
- req_eop  in  N_REQ  per-requester last beat of packet
- req_data  in  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  beat accepted this cycle (one-hot or zero)
- fifo_full  in  1  FIFO full flag
- fifo_wen  out  1  FIFO write enable
- fifo_wdata  out  WIDTH  FIFO write data
- fifo_wsrc  out  SRC_W  id of the requester being written
- busy  out  1  arbiter is locked to a packet

Behaviour:
- Handshake: a beat transfers when req_valid[i] && req_ready[i]. Requesters hold valid, data and eop stable until ready.
- FSM has two states, IDLE and LOCKED, plus registers gnt_id (SRC_W) and rr_ptr (SRC_W).
- IDLE:
  - Pick the first valid requester, searching from rr_ptr upward with wrap. This selection is combinational in the same cycle.
  - If a requester is picked and fifo_full=0: write the beat (fifo_wen=1, req_ready[pick]=1).
  - If that beat has eop=1 (single-beat packet): stay in IDLE and set rr_ptr=pick+1 mod N_REQ.
  - Otherwise: go to LOCKED with gnt_id=pick.
  - If fifo_full=1: no write and no state change; the pick is recomputed next cycle.
- LOCKED:
  - Only gnt_id is eligible.
  - Write when req_valid[gnt_id] && !fifo_full.
  - On a written eop beat: go to IDLE with rr_ptr=gnt_id+1 mod N_REQ.
  - Other requesters' valids are ignored; a bubble on gnt_id keeps the lock.
- Datapath outputs:
  - fifo_wen = req_ready != 0.
  - fifo_wdata/fifo_wsrc are the selected requester's data and id; they are 0 when fifo_wen=0.
  - Latency is zero cycles (combinational from req_valid/fifo_full to ready/wen).
- busy = (state == LOCKED), registered.
- Full: fifo_full=1 forces fifo_wen=0 and all req_ready=0 in any state. The arbiter never causes a FIFO overflow.
- Wrap: rr_ptr wraps N_REQ-1 -> 0. When N_REQ is not a power of two, use an explicit compare, not a natural wrap.
- Reset (rst=1), and likewise clear=1 (same effect, clear has lower priority than rst):
  - state=IDLE, rr_ptr=0, gnt_id=0, busy=0.
  - Outputs are forced 0 during the reset/clear cycle.
  - A packet in flight is abandoned with no eop written. Recovery is upstream's responsibility.

Optional Feature:
- Macro NX_FIFO_WR_ARB_STATS_EN.
- When defined, adds:
  - output beat_cnt [N_REQ*16]: per-requester 16-bit saturating count of accepted beats.
  - output pkt_cnt [N_REQ*16]: per-requester 16-bit saturating count of accepted eop beats.
  - Both cleared by rst or clear, and saturate at 16'hFFFF.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package nx_fifo_wr_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e.
  - localparam STAT_W = 16.
  - Function rr_next(ptr, n) for the wrap increment.
- One sub-module, nx_rr_pick: combinational priority picker. Inputs are req vector and start pointer; outputs are a found flag and the index.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> fifo_wen=0, req_ready=0, busy=0. After release, all valids 0 -> no writes.
- Round-robin fairness: all 4 requesters continuously send single-beat packets (eop=1) with fifo_full=0 -> fifo_wsrc sequence 0,1,2,3,0,1 with one write per cycle.
- Packet lock: req1 sends 3 beats (eop on 3rd) while req0 and req2 stay valid -> 3 consecutive writes with wsrc=1, busy=1 for beats 2-3. The next grant goes to 2.
- Backpressure: fifo_full=1 for 5 cycles mid-packet of req3 -> zero writes and ready=0 for 5 cycles. After fifo_full drops, the packet resumes with no beat lost or duplicated, verified by scoreboard.
- Reset mid-packet: clear=1 during beat 2 of a 4-beat req2 packet -> the next cycle shows state IDLE and rr_ptr=0. A new request from req0 is granted first.
- Stats (with NX_FIFO_WR_ARB_STATS_EN defined): req0 sends 70000 single beats -> beat_cnt[0] and pkt_cnt[0] saturate at 65535 and other requesters' counters stay 0.

Source files
------------

// File: rtl/nx_fifo_wr_arb_pkg.sv
// nx_fifo_wr_arb_pkg
//   Shared types and helpers for the nx_fifo write arbiter.
//   - arb_state_e : arbitration FSM state encoding
//   - STAT_W      : width of the optional per-requester statistics counters
//   - rr_next()   : round-robin pointer increment with explicit wrap at n-1
package nx_fifo_wr_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned STAT_W = 16;

    // Explicit compare so non-power-of-two requester counts wrap correctly.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/nx_rr_pick.sv
// nx_rr_pick
//   Combinational round-robin priority picker: returns the first set bit of
//   req_i, searching upward from start_i and wrapping past N-1 back to 0.
//   Ports:
//     req_i    [N]      request vector
//     start_i  [IDX_W]  index searched first
//     found_o           at least one request is set
//     idx_o    [IDX_W]  index of the chosen request (0 when none)
module nx_rr_pick
    import nx_fifo_wr_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    int unsigned cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 32'(start_i);
        for (int unsigned k = 0; k < N; k++) begin
            if (!found_o && req_i[cand[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
            cand = rr_next(cand, N);
        end
    end

endmodule

// File: rtl/nx_fifo_wr_arb.sv
// nx_fifo_wr_arb
//   Packet-aware round-robin arbiter sharing one nx_fifo write port between
//   N_REQ requesters. A requester that wins keeps the grant until its eop beat
//   is written, so packets never interleave in the FIFO. Zero-cycle latency:
//   ready/wen are combinational from req_valid/fifo_full.
//
//   Handshake: a beat transfers when req_valid_i[i] && req_ready_o[i];
//   requesters hold valid/eop/data stable until ready. The FIFO side is a
//   plain write strobe (fifo_wen_o) qualified by !fifo_full_i.
//
//   Ports:
//     clk_i, rst_i (sync, active-high), clear_i (sync soft reset, below rst_i)
//     req_valid_i/req_eop_i [N_REQ], req_data_i [N_REQ*WIDTH], req_ready_o [N_REQ]
//     fifo_full_i, fifo_wen_o, fifo_wdata_o [WIDTH], fifo_wsrc_o [SRC_W]
//     busy_o          arbiter locked to a packet
//     dbg_state_o     FSM state, dbg_rr_ptr_o / dbg_gnt_id_o arbitration registers
//   Optional (macro NX_FIFO_WR_ARB_STATS_EN):
//     beat_cnt_o, pkt_cnt_o [N_REQ*16]  saturating accepted beat / eop counts
module nx_fifo_wr_arb
    import nx_fifo_wr_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 611,
    parameter int unsigned SRC_W = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ-1:0]       req_eop_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic                   fifo_full_i,
    output logic                   fifo_wen_o,
    output logic [WIDTH-1:0]       fifo_wdata_o,
    output logic [SRC_W-1:0]       fifo_wsrc_o,
    output logic                   busy_o,
    output arb_state_e             dbg_state_o,
    output logic [SRC_W-1:0]       dbg_rr_ptr_o,
    output logic [SRC_W-1:0]       dbg_gnt_id_o
`ifdef NX_FIFO_WR_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] beat_cnt_o,
    output logic [N_REQ*STAT_W-1:0] pkt_cnt_o
`endif
);

    arb_state_e       state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] gnt_id_q, gnt_id_d;

    logic             pick_found;
    logic [SRC_W-1:0] pick_idx;
    logic [SRC_W-1:0] sel_id;
    logic             sel_ok;
    logic             sel_eop;
    logic             blocked;
    logic             wr_en;

    nx_rr_pick #(
        .N     (N_REQ),
        .IDX_W (SRC_W)
    ) u_pick (
        .req_i   (req_valid_i),
        .start_i (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // While locked only the granted requester is eligible; a bubble on it
    // simply produces no write and keeps the lock.
    always_comb begin
        sel_id = '0;
        sel_ok = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                sel_id = pick_idx;
                sel_ok = pick_found;
            end
            ARB_LOCKED: begin
                sel_id = gnt_id_q;
                sel_ok = req_valid_i[gnt_id_q];
            end
            default: begin
                sel_id = '0;
                sel_ok = 1'b0;
            end
        endcase
    end

    assign sel_eop = req_eop_i[sel_id];
    // Reset/clear cycles write nothing; a full FIFO is never written.
    assign blocked = rst_i || clear_i;
    assign wr_en   = sel_ok && !fifo_full_i && !blocked;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            ARB_IDLE: begin
                if (wr_en) begin
                    if (sel_eop) begin
                        rr_ptr_d = SRC_W'(rr_next(32'(sel_id), N_REQ));
                    end else begin
                        state_d  = ARB_LOCKED;
                        gnt_id_d = sel_id;
                    end
                end
            end
            ARB_LOCKED: begin
                if (wr_en && sel_eop) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = SRC_W'(rr_next(32'(gnt_id_q), N_REQ));
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready_o  = '0;
        fifo_wen_o   = 1'b0;
        fifo_wdata_o = '0;
        fifo_wsrc_o  = '0;
        if (wr_en) begin
            req_ready_o[sel_id] = 1'b1;
            fifo_wen_o          = 1'b1;
            fifo_wdata_o        = req_data_i[32'(sel_id)*WIDTH +: WIDTH];
            fifo_wsrc_o         = sel_id;
        end
        busy_o = (state_q == ARB_LOCKED) && !blocked;
    end

    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;
    assign dbg_gnt_id_o = gnt_id_q;

`ifdef NX_FIFO_WR_ARB_STATS_EN
    logic [N_REQ-1:0][STAT_W-1:0] beat_cnt_q;
    logic [N_REQ-1:0][STAT_W-1:0] pkt_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (req_ready_o[i]) begin
                    if (beat_cnt_q[i] != '1) beat_cnt_q[i] <= beat_cnt_q[i] + 1'b1;
                    if (req_eop_i[i] && (pkt_cnt_q[i] != '1)) pkt_cnt_q[i] <= pkt_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign beat_cnt_o = beat_cnt_q;
    assign pkt_cnt_o  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_nx_fifo_wr_arb.sv
// Testbench for nx_fifo_wr_arb: directed per-cycle vectors with hand-computed
// expected grants; a negedge monitor pops and compares against the queues.
module tb_nx_fifo_wr_arb;
    import nx_fifo_wr_arb_pkg::*;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 611;
    localparam int unsigned SRC_W = 2;
    localparam int unsigned W     = SRC_W + WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_eop = '0;
    logic [N_REQ*WIDTH-1:0] req_data = '0;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_full = 1'b0;
    logic                   fifo_wen;
    logic [WIDTH-1:0]       fifo_wdata;
    logic [SRC_W-1:0]       fifo_wsrc;
    logic                   busy;
    arb_state_e             dbg_state;
    logic [SRC_W-1:0]       dbg_rr_ptr;
    logic [SRC_W-1:0]       dbg_gnt_id;
`ifdef NX_FIFO_WR_ARB_STATS_EN
    logic [N_REQ*STAT_W-1:0] beat_cnt;
    logic [N_REQ*STAT_W-1:0] pkt_cnt;
`endif

    nx_fifo_wr_arb #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .SRC_W (SRC_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .req_valid_i  (req_valid),
        .req_eop_i    (req_eop),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .fifo_full_i  (fifo_full),
        .fifo_wen_o   (fifo_wen),
        .fifo_wdata_o (fifo_wdata),
        .fifo_wsrc_o  (fifo_wsrc),
        .busy_o       (busy),
        .dbg_state_o  (dbg_state),
        .dbg_rr_ptr_o (dbg_rr_ptr),
        .dbg_gnt_id_o (dbg_gnt_id)
`ifdef NX_FIFO_WR_ARB_STATS_EN
        ,
        .beat_cnt_o   (beat_cnt),
        .pkt_cnt_o    (pkt_cnt)
`endif
    );

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic             wen;
        logic [SRC_W-1:0] src;
        logic             busy;
        logic             dbg_chk;
    } cyc_t;

    cyc_t           cyc_q[$];
    logic [W-1:0]   exp_q[$];
    int             checks = 0;
    int             errors = 0;

    // requester-side progress (driven by observed ready) and expected progress
    int plen[N_REQ];
    int pb[N_REQ];
    int bc[N_REQ];
    int ebc[N_REQ];

    function automatic logic [WIDTH-1:0] mk(input int src, input int b);
        logic [WIDTH-1:0] d;
        d = '0;
        d[15:0]          = b[15:0];
        d[23:16]         = src[7:0];
        d[WIDTH-1 -: 8]  = src[7:0] ^ 8'hA5;
        d[300 +: 16]     = ~b[15:0];
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One clock of stimulus, applied at posedge+1. exp_src < 0 means no write.
    task automatic step(input logic [N_REQ-1:0] vmask, input logic full, input logic r,
                        input logic c, input int exp_src, input logic exp_busy,
                        input logic dbg_chk);
        cyc_t             rec;
        logic [N_REQ-1:0] rdy;
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i]                = vmask[i];
            req_eop[i]                  = (pb[i] == plen[i] - 1);
            req_data[i*WIDTH +: WIDTH]  = mk(i, bc[i]);
        end
        fifo_full = full;
        rst       = r;
        clear     = c;
        rec.wen     = (exp_src >= 0);
        rec.src     = (exp_src >= 0) ? SRC_W'(exp_src) : '0;
        rec.busy    = exp_busy;
        rec.dbg_chk = dbg_chk;
        cyc_q.push_back(rec);
        if (exp_src >= 0) begin
            exp_q.push_back({SRC_W'(exp_src), mk(exp_src, ebc[exp_src])});
            ebc[exp_src]++;
        end
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (rdy[i]) begin
                bc[i]++;
                pb[i] = (pb[i] == plen[i] - 1) ? 0 : pb[i] + 1;
            end
        end
    endtask

    // ---------------- monitor ----------------
    cyc_t         mrec;
    logic [W-1:0] mexp;

    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mrec = cyc_q.pop_front();
            chk("wen", 64'(fifo_wen), 64'(mrec.wen));
            chk("busy", 64'(busy), 64'(mrec.busy));
            if (mrec.wen) chk("ready", 64'(req_ready), 64'(1) << mrec.src);
            else          chk("ready", 64'(req_ready), 64'(0));
            if (mrec.dbg_chk) begin
                chk("state_after_clear", 64'(dbg_state), 64'(ARB_IDLE));
                chk("rr_after_clear", 64'(dbg_rr_ptr), 64'(0));
            end
        end
        if (fifo_wen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write src=%0d t=%0t", fifo_wsrc, $time);
            end else begin
                mexp = exp_q.pop_front();
                if ({fifo_wsrc, fifo_wdata} !== mexp) begin
                    errors++;
                    $display("FAIL write act=%h exp=%h", {fifo_wsrc, fifo_wdata}, mexp);
                end
            end
        end else begin
            chk("idle_zero", 64'((fifo_wdata == '0) && (fifo_wsrc == '0)), 64'(1));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            plen[i] = 1; pb[i] = 0; bc[i] = 0; ebc[i] = 0;
        end
        @(posedge clk);
        #1;
        // reset with all valids high: outputs forced low
        step(4'b1111, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        // idle, no requests
        repeat (3) step(4'b0000, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);

        // round-robin fairness with single-beat packets, incl. 3 -> 0 wrap
        step(4'b1111, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // rr_ptr -> 1

        // packet lock: req1 3-beat packet with a bubble, req0/req2 ignored
        plen[1] = 3;
        step(4'b0111, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        step(4'b0101, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        step(4'b0111, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        step(4'b0111, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);   // eop, rr_ptr -> 2
        step(4'b0111, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        step(4'b0111, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // rr_ptr -> 1

        // backpressure: 5 full cycles in the middle of a 4-beat req3 packet
        plen[3] = 4;
        step(4'b1000, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        repeat (5) step(4'b1001, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        step(4'b1001, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        step(4'b1001, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0);   // eop, rr_ptr -> 0
        step(4'b1001, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // rr_ptr -> 1
        step(4'b0000, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        // full while idle: nothing written, pick retried next cycle
        step(4'b0001, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);   // rr_ptr -> 1

        // clear during beat 2 of a 4-beat req2 packet
        plen[2] = 4;
        step(4'b0100, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        pb[2] = 0;                                         // upstream restarts its packet
        step(4'b0101, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);   // rr_ptr 0 -> req0 first
        step(4'b0100, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0);   // eop
        step(4'b0000, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);

`ifdef NX_FIFO_WR_ARB_STATS_EN
        // saturation: 70000 single beats from req0 after a fresh reset
        step(4'b0000, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        for (int i = 0; i < N_REQ; i++) pb[i] = 0;
        plen[0] = 1;
        for (int n = 0; n < 70000; n++) step(4'b0001, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("beat_cnt0_sat", 64'(beat_cnt[0 +: 16]), 64'hFFFF);
        chk("pkt_cnt0_sat", 64'(pkt_cnt[0 +: 16]), 64'hFFFF);
        for (int i = 1; i < N_REQ; i++) begin
            chk("beat_cnt_other", 64'(beat_cnt[i*16 +: 16]), 64'(0));
            chk("pkt_cnt_other", 64'(pkt_cnt[i*16 +: 16]), 64'(0));
        end
`endif

        @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
